// File: rtl/mii_pkg.sv
`default_nettype none
// ============================================================================
// mii_pkg : shared types, CRC-32 constants and nibble CRC step for mii_frame_streamer
// Rev 1.0
// ============================================================================
package mii_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TX   = 2'd1,
      ST_IPG  = 2'd2,
      ST_HOLD = 2'd3
   } mii_state_e;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hC704_DD7B;

   // Even nibble index carries bits [3:0] of the byte when set.
   localparam logic NIB_LOW_FIRST = 1'b1;

   function automatic logic [31:0] crc32_nib_step(input logic [31:0] crc, input logic [3:0] nib);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 4; i++) begin
         if (c[0] ^ nib[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
         else               c = c >> 1;
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mii_crc32_nib.sv
`default_nettype none
// ============================================================================
// mii_crc32_nib : reflected CRC-32, one nibble per falling clock edge (used with MII_FCS_GEN_EN)
// Rev 1.0
// ============================================================================
module mii_crc32_nib
   import mii_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_init,
   input  logic        i_en,
   input  logic [3:0]  i_nib,
   output logic [31:0] o_crc
);

   logic [31:0] r_crc;
   logic [31:0] w_base;

   // Init and enable may coincide: the first nibble folds into a fresh seed.
   assign w_base = i_init ? CRC32_INIT : r_crc;

   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  r_crc <= CRC32_INIT;
      else if (i_en) r_crc <= crc32_nib_step(w_base, i_nib);
      else           r_crc <= w_base;
   end

   assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/mii_frame_streamer.sv
`default_nettype none
// ============================================================================
// mii_frame_streamer : streams ROM_IMAGE (byte 0 in bits [7:0]) onto MII TX, low nibble first.
// Optional macro MII_FCS_GEN_EN appends a generated CRC-32 FCS.   Rev 1.0
// ============================================================================
module mii_frame_streamer
   import mii_pkg::*;
#(
   parameter int PKT_SIZE    = 1116,
   parameter int IPG_NIBBLES = 100,
   parameter int FRAME_LIMIT = 0,
   parameter int CRC_START   = 8,
   parameter int CNT_W       = 16,
   parameter logic [PKT_SIZE*8-1:0] ROM_IMAGE = '0
)(
   input  logic             i_tx_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   output logic             o_tx_en,
   output logic [3:0]       o_txd,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_frame_cnt
);

   localparam int ROM_NIBS = 2 * PKT_SIZE;
`ifdef MII_FCS_GEN_EN
   localparam int TOTAL_NIBS = ROM_NIBS + 8;
`else
   localparam int TOTAL_NIBS = ROM_NIBS;
`endif
   localparam int NIB_W  = $clog2(TOTAL_NIBS + 1);
   localparam int BYTE_W = (PKT_SIZE > 1) ? $clog2(PKT_SIZE) : 1;
   localparam int GAP_W  = (IPG_NIBBLES > 1) ? $clog2(IPG_NIBBLES) : 1;

   if (IPG_NIBBLES < 1 || CRC_START < 0 || CRC_START > PKT_SIZE) begin : g_param_check
      $error("mii_frame_streamer: IPG_NIBBLES or CRC_START out of range");
   end

   logic [7:0] w_rom [PKT_SIZE];
   for (genvar g = 0; g < PKT_SIZE; g++) begin : g_rom
      assign w_rom[g] = ROM_IMAGE[g*8 +: 8];
   end

   mii_state_e       r_state, w_state_nx;
   logic [NIB_W-1:0] r_nib, w_nib_nx, w_emit_idx;
   logic [GAP_W-1:0] r_gap, w_gap_nx;
   logic [31:0]      r_frames, w_frames_nx;
   logic [CNT_W-1:0] r_frame_cnt, w_cnt_nx;
   logic             r_tx_en, r_busy, r_done;
   logic [3:0]       r_txd;
   logic             w_start, w_frame_end, w_emit, w_limit_hit;
   logic [7:0]       w_rom_byte;
   logic [3:0]       w_rom_nib, w_data;

   assign w_limit_hit = (FRAME_LIMIT != 0) && (r_frames == 32'(FRAME_LIMIT));

   // r_nib is the index of the next nibble to drive; a frame start always emits nibble 0.
   always_comb begin
      w_state_nx  = r_state;
      w_nib_nx    = r_nib;
      w_gap_nx    = r_gap;
      w_frames_nx = r_frames;
      w_cnt_nx    = r_frame_cnt;
      w_start     = 1'b0;
      w_frame_end = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_frames_nx = '0;
            if (i_enable) w_start = 1'b1;
         end
         ST_TX: begin
            if (r_nib == NIB_W'(TOTAL_NIBS)) begin
               w_frame_end = 1'b1;
               w_state_nx  = ST_IPG;
               w_gap_nx    = GAP_W'(IPG_NIBBLES - 1);
               w_cnt_nx    = r_frame_cnt + 1'b1;
               w_frames_nx = r_frames + 32'd1;
            end
         end
         ST_IPG: begin
            if (r_gap != '0)     w_gap_nx = r_gap - 1'b1;
            else if (w_limit_hit) w_state_nx = ST_HOLD;
            else if (i_enable)    w_start = 1'b1;
            else begin
               w_state_nx  = ST_IDLE;
               w_frames_nx = '0;
            end
         end
         ST_HOLD: begin
            if (!i_enable) begin
               w_state_nx  = ST_IDLE;
               w_frames_nx = '0;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
      if (w_start) w_state_nx = ST_TX;
      w_emit     = w_start || ((r_state == ST_TX) && !w_frame_end);
      w_emit_idx = w_start ? '0 : r_nib;
      if (w_emit) w_nib_nx = w_emit_idx + 1'b1;
   end

   assign w_rom_byte = w_rom[w_emit_idx[BYTE_W:1]];
   assign w_rom_nib  = (w_emit_idx[0] == NIB_LOW_FIRST) ? w_rom_byte[7:4] : w_rom_byte[3:0];

`ifdef MII_FCS_GEN_EN
   logic [31:0] w_crc;
   logic        w_is_fcs, w_crc_en;
   logic [2:0]  w_fcs_sel;

   assign w_is_fcs  = (w_emit_idx >= NIB_W'(ROM_NIBS));
   assign w_fcs_sel = 3'(w_emit_idx - NIB_W'(ROM_NIBS));
   assign w_crc_en  = w_emit && !w_is_fcs && (w_emit_idx >= NIB_W'(2 * CRC_START));

   mii_crc32_nib u_crc (
      .i_clk   (i_tx_clk),
      .i_rst_n (i_rst_n),
      .i_init  (w_start),
      .i_en    (w_crc_en),
      .i_nib   (w_rom_nib),
      .o_crc   (w_crc)
   );

   // CRC register is frozen while the FCS drains, least-significant nibble first.
   assign w_data = w_is_fcs ? ~w_crc[{w_fcs_sel, 2'b00} +: 4] : w_rom_nib;
`else
   assign w_data = w_rom_nib;
`endif

   always_ff @(negedge i_tx_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_nib       <= '0;
         r_gap       <= '0;
         r_frames    <= '0;
         r_frame_cnt <= '0;
         r_tx_en     <= 1'b0;
         r_txd       <= 4'h0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_nib       <= w_nib_nx;
         r_gap       <= w_gap_nx;
         r_frames    <= w_frames_nx;
         r_frame_cnt <= w_cnt_nx;
         r_tx_en     <= w_emit;
         r_txd       <= w_emit ? w_data : 4'h0;
         r_busy      <= (w_state_nx == ST_TX) || (w_state_nx == ST_IPG);
         r_done      <= (w_state_nx == ST_HOLD);
      end
   end

   assign o_tx_en     = r_tx_en;
   assign o_txd       = r_txd;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mii_frame_streamer.sv
`default_nettype none
// ============================================================================
// tb_mii_frame_streamer : scoreboard bench; expected nibbles queued by stimulus, popped by monitors
// Rev 1.0
// ============================================================================
module tb_mii_frame_streamer;

`ifdef MII_FCS_GEN_EN
   localparam int EXTRA = 8;
`else
   localparam int EXTRA = 0;
`endif
   localparam int NS = 8 + EXTRA;
   localparam logic [31:0] ROM_S = {8'h78, 8'h56, 8'h34, 8'h12};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int seen_a = 0;
   int base, gap;

   logic rst_n, rst_a;
   logic en_a, en_b, en_c;
   logic tx_en_a, busy_a, done_a, tx_en_b, busy_b, done_b, tx_en_c, busy_c, done_c;
   logic [3:0]  txd_a, txd_b, txd_c;
   logic [15:0] cnt_a, cnt_b;
   logic [3:0]  cnt_c;

   logic [3:0] exp_nib [8] = '{4'h2, 4'h1, 4'h4, 4'h3, 4'h6, 4'h5, 4'h8, 4'h7};
   logic [3:0] q_a[$];
   logic [3:0] q_b[$];

   mii_frame_streamer #(.PKT_SIZE(4), .IPG_NIBBLES(3), .FRAME_LIMIT(0), .CRC_START(4),
                        .CNT_W(16), .ROM_IMAGE(ROM_S)) u_a (
      .i_tx_clk(clk), .i_rst_n(rst_a), .i_enable(en_a), .o_tx_en(tx_en_a), .o_txd(txd_a),
      .o_busy(busy_a), .o_done(done_a), .o_frame_cnt(cnt_a));

   mii_frame_streamer #(.PKT_SIZE(4), .IPG_NIBBLES(3), .FRAME_LIMIT(2), .CRC_START(4),
                        .CNT_W(16), .ROM_IMAGE(ROM_S)) u_b (
      .i_tx_clk(clk), .i_rst_n(rst_n), .i_enable(en_b), .o_tx_en(tx_en_b), .o_txd(txd_b),
      .o_busy(busy_b), .o_done(done_b), .o_frame_cnt(cnt_b));

   mii_frame_streamer #(.PKT_SIZE(4), .IPG_NIBBLES(3), .FRAME_LIMIT(0), .CRC_START(4),
                        .CNT_W(4), .ROM_IMAGE(ROM_S)) u_c (
      .i_tx_clk(clk), .i_rst_n(rst_n), .i_enable(en_c), .o_tx_en(tx_en_c), .o_txd(txd_c),
      .o_busy(busy_c), .o_done(done_c), .o_frame_cnt(cnt_c));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input bit to_b);
      logic [3:0] n;
      for (int i = 0; i < NS; i++) begin
         n = (i < 8) ? exp_nib[i] : 4'h0;
         if (to_b) q_b.push_back(n);
         else      q_a.push_back(n);
      end
   endtask

   function automatic logic [31:0] ref_crc_byte(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   always @(posedge clk) begin
      if (tx_en_a) begin
         seen_a++;
         if (q_a.size() == 0) begin
            total++; bad++;
            $display("FAIL a_nib unexpected got=%0h exp=none", txd_a);
         end else chk("a_nib", 32'(txd_a), 32'(q_a.pop_front()));
      end else chk("a_txd_idle", 32'(txd_a), 32'd0);
      if (tx_en_b) begin
         if (q_b.size() == 0) begin
            total++; bad++;
            $display("FAIL b_nib unexpected got=%0h exp=none", txd_b);
         end else chk("b_nib", 32'(txd_b), 32'(q_b.pop_front()));
      end else chk("b_txd_idle", 32'(txd_b), 32'd0);
      if (!tx_en_c) chk("c_txd_idle", 32'(txd_c), 32'd0);
   end

`ifdef MII_FCS_GEN_EN
   localparam int PKT_F = 68;
   function automatic logic [PKT_F*8-1:0] build_rom_f();
      logic [PKT_F*8-1:0] r;
      for (int i = 0; i < 7; i++) r[i*8 +: 8] = 8'h55;
      r[56 +: 8] = 8'hD5;
      for (int j = 0; j < 60; j++) r[(8+j)*8 +: 8] = 8'(j);
      return r;
   endfunction
   localparam logic [PKT_F*8-1:0] ROM_F = build_rom_f();

   logic        en_f, tx_en_f, busy_f, done_f;
   logic [3:0]  txd_f;
   logic [15:0] cnt_f;
   logic [3:0]  q_f[$];
   logic [3:0]  obs_f[$];

   mii_frame_streamer #(.PKT_SIZE(PKT_F), .IPG_NIBBLES(3), .FRAME_LIMIT(0), .CRC_START(8),
                        .CNT_W(16), .ROM_IMAGE(ROM_F)) u_f (
      .i_tx_clk(clk), .i_rst_n(rst_n), .i_enable(en_f), .o_tx_en(tx_en_f), .o_txd(txd_f),
      .o_busy(busy_f), .o_done(done_f), .o_frame_cnt(cnt_f));

   always @(posedge clk) begin
      if (tx_en_f) begin
         obs_f.push_back(txd_f);
         if (q_f.size() == 0) begin
            total++; bad++;
            $display("FAIL f_nib unexpected got=%0h exp=none", txd_f);
         end else chk("f_nib", 32'(txd_f), 32'(q_f.pop_front()));
      end
   end
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rst_a = 1'b0;
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
`ifdef MII_FCS_GEN_EN
      en_f = 1'b0;
`endif
      repeat (3) tick();
      chk("a_rst_tx_en", 32'(tx_en_a), 32'd0);
      chk("a_rst_txd",   32'(txd_a),   32'd0);
      chk("a_rst_busy",  32'(busy_a),  32'd0);
      chk("a_rst_done",  32'(done_a),  32'd0);
      chk("a_rst_cnt",   32'(cnt_a),   32'd0);
      rst_a = 1'b1; rst_n = 1'b1;
      tick();

      // Back-to-back frames with ENABLE held
      push_frame(0); push_frame(0);
      en_a = 1'b1;
      for (int k = 0; k < 100 && cnt_a != 16'd1; k++) tick();
      chk("a_cnt_first", 32'(cnt_a), 32'd1);
      chk("a_busy_ipg",  32'(busy_a), 32'd1);
      gap = 0;
      while (!tx_en_a && gap < 20) begin gap++; tick(); end
      chk("a_gap", 32'(gap), 32'd3);
      for (int k = 0; k < 100 && cnt_a != 16'd2; k++) tick();
      en_a = 1'b0;
      chk("a_cnt_second", 32'(cnt_a), 32'd2);
      repeat (6) tick();
      chk("a_idle_busy", 32'(busy_a), 32'd0);
      chk("a_idle_q",    32'(q_a.size()), 32'd0);

      // ENABLE dropped on third nibble
      push_frame(0); base = seen_a; en_a = 1'b1;
      for (int k = 0; k < 50 && seen_a < base + 3; k++) tick();
      en_a = 1'b0;
      for (int k = 0; k < 100 && cnt_a != 16'd3; k++) tick();
      chk("a_drop_cnt", 32'(cnt_a), 32'd3);
      repeat (5) tick();
      chk("a_drop_busy", 32'(busy_a), 32'd0);
      chk("a_drop_nibs", 32'(seen_a - base), 32'(NS));
      chk("a_drop_q",    32'(q_a.size()), 32'd0);

      // Async reset mid-frame
      push_frame(0); base = seen_a; en_a = 1'b1;
      for (int k = 0; k < 50 && seen_a < base + 5; k++) tick();
      rst_a = 1'b0;
      #1;
      chk("a_mid_rst_tx_en", 32'(tx_en_a), 32'd0);
      chk("a_mid_rst_txd",   32'(txd_a),   32'd0);
      chk("a_mid_rst_busy",  32'(busy_a),  32'd0);
      chk("a_mid_rst_cnt",   32'(cnt_a),   32'd0);
      q_a.delete();
      tick();
      push_frame(0);
      rst_a = 1'b1;
      for (int k = 0; k < 100 && cnt_a != 16'd1; k++) tick();
      en_a = 1'b0;
      chk("a_restart_cnt", 32'(cnt_a), 32'd1);
      repeat (5) tick();
      chk("a_restart_q", 32'(q_a.size()), 32'd0);

      // FRAME_LIMIT = 2
      push_frame(1); push_frame(1);
      en_b = 1'b1;
      for (int k = 0; k < 200 && !done_b; k++) tick();
      chk("b_done1", 32'(done_b), 32'd1);
      chk("b_cnt1",  32'(cnt_b),  32'd2);
      chk("b_busy_hold", 32'(busy_b), 32'd0);
      chk("b_q1", 32'(q_b.size()), 32'd0);
      repeat (15) tick();
      chk("b_hold_tx_en", 32'(tx_en_b), 32'd0);
      chk("b_hold_done",  32'(done_b),  32'd1);
      en_b = 1'b0;
      repeat (2) tick();
      chk("b_done_clear", 32'(done_b), 32'd0);
      push_frame(1); push_frame(1);
      en_b = 1'b1;
      for (int k = 0; k < 200 && !done_b; k++) tick();
      chk("b_done2", 32'(done_b), 32'd1);
      chk("b_cnt2",  32'(cnt_b),  32'd4);
      chk("b_q2", 32'(q_b.size()), 32'd0);
      en_b = 1'b0;

      // CNT_W = 4 wrap over 17 frames
      en_c = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         for (int j = 0; j < 100 && !tx_en_c; j++) tick();
         for (int j = 0; j < 100 && tx_en_c; j++) tick();
         chk("c_cnt", 32'(cnt_c), 32'(k % 16));
      end
      en_c = 1'b0;
      repeat (6) tick();
      chk("c_idle_busy", 32'(busy_c), 32'd0);
      chk("c_done", 32'(done_c), 32'd0);

`ifdef MII_FCS_GEN_EN
      begin
         logic [31:0] crc, rx;
         logic [7:0]  by;
         crc = 32'hFFFFFFFF;
         for (int b = 8; b < PKT_F; b++) crc = ref_crc_byte(crc, ROM_F[b*8 +: 8]);
         crc = ~crc;
         for (int i = 0; i < 2 * PKT_F; i++) begin
            by = ROM_F[(i/2)*8 +: 8];
            q_f.push_back((i % 2 == 1) ? by[7:4] : by[3:0]);
         end
         for (int k = 0; k < 8; k++) q_f.push_back(crc[k*4 +: 4]);
         en_f = 1'b1;
         for (int k = 0; k < 400 && cnt_f != 16'd1; k++) tick();
         en_f = 1'b0;
         repeat (5) tick();
         chk("f_q", 32'(q_f.size()), 32'd0);
         chk("f_len", 32'(obs_f.size()), 32'(2 * PKT_F + 8));
         rx = 32'hFFFFFFFF;
         for (int b = 8; b < PKT_F + 4; b++) begin
            by = {obs_f[2*b+1], obs_f[2*b]};
            rx = ref_crc_byte(rx, by);
         end
         chk("f_residue", {<<{rx}}, 32'hC704DD7B);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
